// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequenced floating-point add/subtract unit.
// Helpers take the field widths as arguments so any EXP_W/MAN_W instance can use them.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        ALN,
        ADD,
        NRM,
        DONE
    } state_t;

    // Wide enough for any practical format; callers slice down to their widths.
    typedef struct packed {
        logic        sign;
        logic [31:0] exp;
        logic [63:0] man;
    } unpacked_t;

    function automatic logic [127:0] qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    // exp==0 is treated as zero: denormal fractions are dropped, hidden bit added otherwise.
    function automatic unpacked_t unpack(input logic [127:0] v, input int exp_w, input int man_w);
        unpacked_t   u;
        logic [127:0] e_mask;
        logic [127:0] m_mask;
        e_mask = (128'd1 << exp_w) - 128'd1;
        m_mask = (128'd1 << man_w) - 128'd1;
        u.sign = v[exp_w + man_w];
        u.exp  = 32'((v >> man_w) & e_mask);
        if (u.exp == 32'd0) u.man = '0;
        else                u.man = 64'(v & m_mask) | (64'd1 << man_w);
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 25,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Scanning upward lets the highest set bit take the final assignment.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract: one pipeline step (compare, align,
// add, normalise) per cycle, truncating, with valid/ready on both sides.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    input  logic                     op_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     neg
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 1;
    localparam int SW  = MAN_W + 2;
    localparam int CW  = $clog2(SW + 1);
    localparam int EW2 = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN_L   = W'(qnan(EXP_W, MAN_W));

    state_t           state;
    logic [W-1:0]     a_reg, b_reg;
    logic             sub_reg;
    logic             sign_reg, eff_sub_reg, spec_reg;
    logic [W-1:0]     spec_res_reg;
    logic [EXP_W-1:0] exp_l_reg, diff_reg;
    logic [MW-1:0]    man_l_reg, man_s_reg;
    logic [SW-1:0]    sum_reg;

    // Compare-stage decode
    unpacked_t        ua, ub;
    logic [EXP_W-1:0] ea, eb;
    logic [MW-1:0]    ma, mb;
    logic             sb_eff, eff_sub, a_ge;
    logic             inf_a, inf_b, nan_a, nan_b, spec;
    logic [W-1:0]     spec_res;

    assign ua      = unpack(128'(a_reg), EXP_W, MAN_W);
    assign ub      = unpack(128'(b_reg), EXP_W, MAN_W);
    assign ea      = ua.exp[EXP_W-1:0];
    assign eb      = ub.exp[EXP_W-1:0];
    assign ma      = ua.man[MW-1:0];
    assign mb      = ub.man[MW-1:0];
    assign sb_eff  = ub.sign ^ sub_reg;
    assign eff_sub = ua.sign ^ sb_eff;
    assign a_ge    = {ea, ma} >= {eb, mb};
    assign inf_a   = (ea == EXP_ONES) && (a_reg[MAN_W-1:0] == '0);
    assign inf_b   = (eb == EXP_ONES) && (b_reg[MAN_W-1:0] == '0);
    assign nan_a   = (ea == EXP_ONES) && (a_reg[MAN_W-1:0] != '0);
    assign nan_b   = (eb == EXP_ONES) && (b_reg[MAN_W-1:0] != '0);
    assign spec    = (ea == EXP_ONES) || (eb == EXP_ONES);

    always_comb begin
        spec_res = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) spec_res = QNAN_L;
        else if (inf_a)                                    spec_res = {ua.sign, EXP_ONES, {MAN_W{1'b0}}};
    end

    // Align and add stages
    logic [MW-1:0] shifted;
    logic [SW-1:0] sum;

    assign shifted = (32'(diff_reg) > MAN_W + 1) ? '0 : (man_s_reg >> diff_reg);
    assign sum     = eff_sub_reg ? ({1'b0, man_l_reg} - {1'b0, man_s_reg})
                                 : ({1'b0, man_l_reg} + {1'b0, man_s_reg});

    // Normalise stage
    logic [CW-1:0]    lz;
    logic             carry;
    logic [EXP_W:0]   exp_inc;
    logic [SW-1:0]    shl;
    logic [MW-1:0]    norm_man;
    logic [EW2-1:0]   e_nrm;
    logic             uf_cond;
    logic [W-1:0]     res;
    logic             res_ov, res_uf;

    fp_lzc #(.W(SW), .CW(CW)) u_lzc (
        .din (sum_reg),
        .cnt (lz)
    );

    assign carry    = sum_reg[SW-1];
    assign exp_inc  = {1'b0, exp_l_reg} + 1'b1;
    assign shl      = sum_reg << (lz - CW'(1));
    assign norm_man = carry ? sum_reg[SW-1:1] : shl[MW-1:0];
    assign e_nrm    = EW2'(exp_l_reg) - EW2'(lz) + EW2'(1);
    assign uf_cond  = e_nrm[EW2-1] || (e_nrm == '0);

    always_comb begin
        res    = {sign_reg, e_nrm[EXP_W-1:0], norm_man[MAN_W-1:0]};
        res_ov = 1'b0;
        res_uf = 1'b0;
        if (spec_reg) begin
            res = spec_res_reg;
        end else if (sum_reg == '0) begin
            res = {sign_reg & ~eff_sub_reg, {(W-1){1'b0}}};
        end else if (carry) begin
            if (exp_inc[EXP_W-1:0] == EXP_ONES) begin
                res    = {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
                res_ov = 1'b1;
            end else begin
                res = {sign_reg, exp_inc[EXP_W-1:0], norm_man[MAN_W-1:0]};
            end
        end else if (uf_cond) begin
            res    = {sign_reg, {(W-1){1'b0}}};
            res_uf = 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ua.exp, ua.man, ub.exp, ub.man, exp_inc[EXP_W], norm_man[MAN_W], shl};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            result       <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            neg          <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            sub_reg      <= 1'b0;
            sign_reg     <= 1'b0;
            eff_sub_reg  <= 1'b0;
            spec_reg     <= 1'b0;
            spec_res_reg <= '0;
            exp_l_reg    <= '0;
            diff_reg     <= '0;
            man_l_reg    <= '0;
            man_s_reg    <= '0;
            sum_reg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= op_a;
                        b_reg    <= op_b;
                        sub_reg  <= op_sub;
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    sign_reg     <= a_ge ? ua.sign : sb_eff;
                    eff_sub_reg  <= eff_sub;
                    spec_reg     <= spec;
                    spec_res_reg <= spec_res;
                    exp_l_reg    <= a_ge ? ea : eb;
                    diff_reg     <= a_ge ? (ea - eb) : (eb - ea);
                    man_l_reg    <= a_ge ? ma : mb;
                    man_s_reg    <= a_ge ? mb : ma;
                    state        <= ALN;
                end
                ALN: begin
                    man_s_reg <= shifted;
                    state     <= ADD;
                end
                ADD: begin
                    sum_reg <= sum;
                    state   <= NRM;
                end
                NRM: begin
                    result    <= res;
                    overflow  <= res_ov;
                    underflow <= res_uf;
                    neg       <= res[W-1];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (single precision): vector table plus
// backpressure and mid-operation reset sequences.
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow, underflow, neg;

    int tests = 0;
    int fails = 0;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        ov;
        logic        uf;
        logic        ng;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one operation at a negedge; returns once the accepting edge has passed.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid shows, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t vecs[9];
    int   lat;
    logic [31:0] held;

    initial begin
        vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h3FC00000, 32'h40000000, 1'b1, 32'hBF000000, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_result", result, 32'h0);
        check("reset_flags", {29'd0, overflow, underflow, neg}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            out_ready = 1'b1;
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_valid(lat);
            // The accepting edge is the first of five, so out_valid shows four edges later.
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
            check($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].uf));
            check($sformatf("v%0d_neg", i), 32'(neg), 32'(vecs[i].ng));
            $display("[TB] vec %0d: %h %s %h -> %h ov=%0b uf=%0b neg=%0b", i, vecs[i].a,
                     vecs[i].sub ? "-" : "+", vecs[i].b, result, overflow, underflow, neg);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_in_ready_after", i), 32'(in_ready), 32'd1);
            check($sformatf("v%0d_out_valid_after", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: -1.0 + -2.0 = -3.0 held in DONE for four cycles.
        out_ready = 1'b0;
        start_op(32'hBF800000, 32'hC0000000, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        check("bp_result", result, 32'hC0400000);
        held = result;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            op_a     = 32'h3F800000;
            op_b     = 32'h3F800000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("bp_hold%0d_result", k), result, held);
            check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold%0d_flags", k), {29'd0, overflow, underflow, neg}, 32'd1);
        end
        $display("[TB] backpressure: held %h for 4 cycles", result);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_idle_stays_valid", 32'(out_valid), 32'd0);
        check("bp_idle_stays_ready", 32'(in_ready), 32'd1);

        // Reset while the aborted operation sits in ALN.
        start_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset asserted during ALN");
        start_op(32'h40400000, 32'h3F800000, 1'b0);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_result", result, 32'h40800000);
        check("post_rst_flags", {29'd0, overflow, underflow, neg}, 32'd0);
        $display("[TB] post-reset: 40400000 + 3f800000 -> %h", result);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
